// File: rtl/seg_scan_driver_if.sv
// Display-side bus of seg_scan_driver: value load strobe in, digit index/nibble/status out.
// The blank signal exists only when SEG_SCAN_LZ_BLANK_EN is defined.
interface seg_scan_driver_if;
  logic [31:0] data_in;
  logic        load;
  logic [2:0]  count;
  logic [3:0]  x;
  logic        pending;
  logic        frame_done;
`ifdef SEG_SCAN_LZ_BLANK_EN
  logic        blank;

  modport master (output data_in, load,
                  input  count, x, pending, frame_done, blank);
  modport slave  (input  data_in, load,
                  output count, x, pending, frame_done, blank);
`else
  modport master (output data_in, load,
                  input  count, x, pending, frame_done);
  modport slave  (input  data_in, load,
                  output count, x, pending, frame_done);
`endif
endinterface

// File: rtl/seg_scan_driver.sv
// Eight-digit seven-segment scan controller with frame-boundary double buffering.
// Optional leading-zero blanking output enabled by SEG_SCAN_LZ_BLANK_EN.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned DIV_W    = 24
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_driver_if.slave bus
);

  localparam int unsigned DISP_W = 32;
  localparam int unsigned CNT_W  = 3;

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic [DISP_W-1:0] pend_data_q, pend_data_d;
  logic              pending_q, pending_d;
  logic              frame_done_q, frame_done_d;

  logic              tick_c;
  logic              wrap_c;
  logic [4:0]        x_lsb_c;

  assign tick_c = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
  assign wrap_c = tick_c && (count_q == CNT_W'(7));

  // Next-state: prescaler, digit index, pending buffer and frame commit
  always_comb begin
    div_cnt_d    = div_cnt_q + DIV_W'(1);
    count_d      = count_q;
    disp_d       = disp_q;
    pend_data_d  = pend_data_q;
    pending_d    = pending_q;
    frame_done_d = wrap_c;

    if (tick_c) begin
      div_cnt_d = '0;
      count_d   = count_q + CNT_W'(1);
    end

    if (bus.load) begin
      pend_data_d = bus.data_in;
      pending_d   = 1'b1;
    end

    // A load in the wrap cycle bypasses the buffer so it is never one frame late
    if (wrap_c) begin
      if (bus.load) begin
        disp_d = bus.data_in;
      end else if (pending_q) begin
        disp_d = pend_data_q;
      end
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      count_q      <= '0;
      disp_q       <= '0;
      pend_data_q  <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      count_q      <= count_d;
      disp_q       <= disp_d;
      pend_data_q  <= pend_data_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Digit 0 is the leftmost nibble, so its LSB index is 4*(7-count) = {~count, 2'b00}
  assign x_lsb_c = {~count_q, 2'b00};

  assign bus.count      = count_q;
  assign bus.x          = disp_q[x_lsb_c +: 4];
  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_done_q;

`ifdef SEG_SCAN_LZ_BLANK_EN
  // Blank while this nibble and everything to its left is zero; rightmost digit always shown
  assign bus.blank = (count_q != CNT_W'(7)) && ((disp_q >> x_lsb_c) == DISP_W'(0));
`endif

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: SCAN_DIV=4 instance for buffering/commit,
// SCAN_DIV=1 instance for the every-cycle tick case.
module tb_seg_scan_driver;

  logic clk = 1'b0;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;

  seg_scan_driver_if bus4 ();
  seg_scan_driver_if bus1 ();

  seg_scan_driver #(.SCAN_DIV(4), .DIV_W(24)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  seg_scan_driver #(.SCAN_DIV(1), .DIV_W(24)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [3:0] nib(input logic [31:0] v, input int k);
    logic [31:0] t;
    t = v >> (28 - 4 * k);
    return t[3:0];
  endfunction

  function automatic logic blank_exp(input logic [31:0] v, input int k);
    logic [31:0] t;
    t = v >> (28 - 4 * k);
    return (k != 7) && (t == 32'd0);
  endfunction

  // Step until cyc==to, checking both instances against the cycle-derived model each cycle
  task automatic run_check(input int to, input logic [31:0] val);
    int k;
    while (cyc < to) begin
      step();
      k = (cyc / 4) % 8;
      check_eq("count4", 32'(bus4.count), 32'(k));
      check_eq("x4", 32'(bus4.x), 32'(nib(val, k)));
      check_eq("frame_done4", 32'(bus4.frame_done), 32'((cyc % 32 == 0) && (cyc > 0)));
`ifdef SEG_SCAN_LZ_BLANK_EN
      check_eq("blank4", 32'(bus4.blank), 32'(blank_exp(val, k)));
`endif
      check_eq("count1", 32'(bus1.count), 32'(cyc % 8));
      check_eq("frame_done1", 32'(bus1.frame_done), 32'((cyc % 8 == 0) && (cyc > 0)));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus4.load = 1'b0;
    bus4.data_in = '0;
    bus1.load = 1'b0;
    bus1.data_in = '0;
    step();
    step();
    rst = 1'b0;
    cyc = 0;

    // Reset state
    check_eq("rst_count", 32'(bus4.count), 32'd0);
    check_eq("rst_x", 32'(bus4.x), 32'd0);
    check_eq("rst_pending", 32'(bus4.pending), 32'd0);
    check_eq("rst_frame_done", 32'(bus4.frame_done), 32'd0);
`ifdef SEG_SCAN_LZ_BLANK_EN
    check_eq("rst_blank", 32'(bus4.blank), 32'd1);
`endif

    // Load at cycle 2, held pending until the wrap tick at cycle 31
    run_check(2, 32'h0);
    bus4.data_in = 32'h12345678;
    bus4.load = 1'b1;
    step();
    bus4.load = 1'b0;
    check_eq("pend_after_load", 32'(bus4.pending), 32'd1);
    check_eq("x_before_commit", 32'(bus4.x), 32'd0);
    run_check(31, 32'h0);
    check_eq("pend_at_31", 32'(bus4.pending), 32'd1);
    step();
    check_eq("pend_at_32", 32'(bus4.pending), 32'd0);
    check_eq("fd_at_32", 32'(bus4.frame_done), 32'd1);
    check_eq("count_at_32", 32'(bus4.count), 32'd0);
    check_eq("x_at_32", 32'(bus4.x), 32'd1);
    run_check(65, 32'h12345678);

    // Two loads in one frame: last one wins, first never shown
    bus4.data_in = 32'hAAAAAAAA;
    bus4.load = 1'b1;
    step();
    bus4.load = 1'b0;
    check_eq("pend_aaaa", 32'(bus4.pending), 32'd1);
    run_check(70, 32'h12345678);
    bus4.data_in = 32'hBBBBBBBB;
    bus4.load = 1'b1;
    step();
    bus4.load = 1'b0;
    run_check(95, 32'h12345678);
    run_check(96, 32'hBBBBBBBB);
    check_eq("pend_bbbb_commit", 32'(bus4.pending), 32'd0);
    run_check(127, 32'hBBBBBBBB);

    // Load exactly on the wrap tick commits at that edge
    bus4.data_in = 32'hCAFEF00D;
    bus4.load = 1'b1;
    step();
    bus4.load = 1'b0;
    check_eq("bypass_pending", 32'(bus4.pending), 32'd0);
    check_eq("bypass_x", 32'(bus4.x), 32'hC);
    check_eq("bypass_fd", 32'(bus4.frame_done), 32'd1);
    run_check(136, 32'hCAFEF00D);

    // Reset mid-frame at count 5 with a value pending
    bus4.data_in = 32'hDEADBEEF;
    bus4.load = 1'b1;
    step();
    bus4.load = 1'b0;
    check_eq("pend_dead", 32'(bus4.pending), 32'd1);
    run_check(148, 32'hCAFEF00D);
    check_eq("count_before_rst", 32'(bus4.count), 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
    check_eq("mid_rst_count", 32'(bus4.count), 32'd0);
    check_eq("mid_rst_x", 32'(bus4.x), 32'd0);
    check_eq("mid_rst_pending", 32'(bus4.pending), 32'd0);
    check_eq("mid_rst_fd", 32'(bus4.frame_done), 32'd0);
    check_eq("mid_rst_count1", 32'(bus1.count), 32'd0);
    run_check(36, 32'h0);

    // Leading-zero pattern; also exercises blanking when compiled in
    bus4.data_in = 32'h00000A05;
    bus4.load = 1'b1;
    step();
    bus4.load = 1'b0;
    run_check(63, 32'h0);
    run_check(100, 32'h00000A05);
    check_eq("final_pending", 32'(bus4.pending), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
